div_seq: RTL and testbench
==========================

// Module: div_seq
// PURPOSE
//  Upstream sequencer for the 4-bit iterative divider (module div). Accepts dividend/divisor
//  pairs on a valid/ready input stream, pulses the divider's reset to start each operation,
//  holds operands stable, waits for the divider's valid, and presents quotient/remainder on a
//  valid/ready output stream. Handles divide-by-zero locally and guards against a stuck divider.
// PARAMETERS
//  W        4   operand width; must match the divider (fixed 4 in current div)
//  TIMEOUT  15  max WAIT cycles before reporting out_err (range 9..255)
// PORTS
//  clk          in   1  clock, all logic on rising edge
//  rst          in   1  synchronous reset, active-high
//  in_valid     in   1  operand pair available
//  in_ready     out  1  block can accept an operand pair
//  in_D         in   W  dividend
//  in_d         in   W  divisor
//  out_valid    out  1  result available
//  out_ready    in   1  consumer accepts result
//  out_q        out  W  quotient
//  out_r        out  W  remainder
//  out_dbz      out  1  result is divide-by-zero
//  out_err      out  1  divider timed out
//  div_rst      out  1  to divider rst
//  div_D        out  W  to divider D
//  div_d        out  W  to divider d
//  div_q        in   W  from divider q
//  div_r        in   W  from divider r
//  div_valid    in   1  from divider valid
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=0 during rst then 1, out_valid/out_dbz/out_err=0, out_q/out_r=0,
//   div_D/div_d=0, wait counter=0. div_rst = rst | (state==START) (combinational OR).
//  States: IDLE, START, WAIT, DONE.
//  IDLE: in_ready=1. On in_valid: register in_D->div_D, in_d->div_d.
//   in_d!=0 -> START. in_d==0 -> DONE with out_q={W{1}}, out_r=in_D, out_dbz=1 (divider not run).
//  START: one cycle, div_rst=1; div_valid ignored (stale from previous op). -> WAIT, counter=0.
//  WAIT: div_rst=0; div_D/div_d held stable (divider samples D one cycle after its reset).
//   div_valid=1 -> capture div_q/div_r into out_q/out_r, out_dbz=0, out_err=0 -> DONE.
//   else counter+1; counter==TIMEOUT-1 without valid -> out_q=0, out_r=0, out_err=1 -> DONE.
//  DONE: out_valid=1, outputs held stable until out_ready; on out_valid&out_ready -> IDLE,
//   out_valid=0 next cycle. in_ready=0 in START/WAIT/DONE (one operation in flight).
//  Latency (d!=0): accept in cycle 0 -> START c1 -> divider loads c2, iterates c3..c6,
//   div_valid in c7 -> out_valid=1 from c8. Throughput 1 op per 9 cycles with out_ready=1.
//  d==0: accept c0 -> out_valid c1.
//  rst mid-operation: abandon op, return to reset state next cycle; div_rst asserted during rst.
//  out_ready asserted while out_valid=0: no effect. in_valid while in_ready=0: not accepted.
// TESTING
//  1 rst 2 cycles -> in_ready=1, out_valid=0, div_rst=1 during rst, 0 after.
//  2 D=13,d=3, out_ready=1 -> out_valid at cycle 8 after accept, q=4, r=1, dbz=0, err=0.
//  3 D=15,d=1 then D=2,d=7 back-to-back -> q=15,r=0 then q=0,r=2; in_ready low between ops.
//  4 D=9,d=0 -> out_valid one cycle after accept, q=15, r=9, dbz=1; div_rst never pulses.
//  5 D=7,d=2 with out_ready=0 for 5 cycles -> q=3,r=1 held stable; in_ready stays 0.
//  6 divider model tied div_valid=0 -> out_err=1, q=r=0 after TIMEOUT WAIT cycles;
//    rst asserted in WAIT -> IDLE next cycle, no out_valid.

Source files
------------

// File: rtl/div_seq.sv
// Sequencer for the 4-bit iterative divider: takes operand pairs in, starts the divider,
// and hands quotient/remainder out. Divide-by-zero and a stuck divider are handled here.
module div_seq #(
  parameter int W       = 4,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_D,
  input  logic [W-1:0] in_d,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_q,
  output logic [W-1:0] out_r,
  output logic         out_dbz,
  output logic         out_err,
  output logic         div_rst,
  output logic [W-1:0] div_D,
  output logic [W-1:0] div_d,
  input  logic [W-1:0] div_q,
  input  logic [W-1:0] div_r,
  input  logic         div_valid
);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic       timed_out;

  assign timed_out = (cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // div_valid is deliberately not looked at in START: it may still be high from the last op.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    div_rst   = rst;
    case (state)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid) state_nxt = (in_d == '0) ? DONE : START;
      end
      START: begin
        div_rst   = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (div_valid || timed_out) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_D   <= '0;
      div_d   <= '0;
      out_q   <= '0;
      out_r   <= '0;
      out_dbz <= 1'b0;
      out_err <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            div_D <= in_D;
            div_d <= in_d;
            if (in_d == '0) begin
              out_q   <= '1;
              out_r   <= in_D;
              out_dbz <= 1'b1;
              out_err <= 1'b0;
            end
          end
        end
        START: cnt <= '0;
        WAIT: begin
          if (div_valid) begin
            out_q   <= div_q;
            out_r   <= div_r;
            out_dbz <= 1'b0;
            out_err <= 1'b0;
          end else if (timed_out) begin
            out_q   <= '0;
            out_r   <= '0;
            out_dbz <= 1'b0;
            out_err <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: a behavioural divider plus an arithmetic reference model checks
// directed and random operand pairs, divide-by-zero, stalls, timeout and mid-op reset.
module tb_div_seq;
  localparam int W       = 4;
  localparam int TIMEOUT = 15;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_D, in_d, out_q, out_r, div_D, div_d, div_q, div_r;
  logic         out_dbz, out_err, div_rst, div_valid;

  int checks = 0;
  int errors = 0;
  bit stuck  = 1'b0;

  div_seq #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_D(in_D), .in_d(in_d),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_r(out_r),
    .out_dbz(out_dbz), .out_err(out_err),
    .div_rst(div_rst), .div_D(div_D), .div_d(div_d),
    .div_q(div_q), .div_r(div_r), .div_valid(div_valid)
  );

  always #5 clk = ~clk;

  // Divider stand-in: loads one cycle after its reset, valid five cycles later, stays valid.
  logic [2:0]   phase = 3'd0;
  logic [W-1:0] lat_D = '0, lat_d = '0;
  always @(posedge clk) begin
    if (div_rst) phase <= 3'd1;
    else if (phase != 3'd0 && phase < 3'd6) phase <= phase + 3'd1;
    if (phase == 3'd1) begin
      lat_D <= div_D;
      lat_d <= div_d;
    end
  end
  assign div_valid = (phase == 3'd6) && !stuck;
  assign div_q     = (lat_d == '0) ? '0 : lat_D / lat_d;
  assign div_r     = (lat_d == '0) ? '0 : lat_D % lat_d;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full operation: accept, wait with bounded budget, optional output stall, handshake.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input int stall, input bit exp_stuck);
    logic [W-1:0] eq, er;
    logic         edbz, eerr;
    int           elat, n;
    if (b == 0) begin
      eq = 4'hF; er = a; edbz = 1'b1; eerr = 1'b0; elat = 1;
    end else if (exp_stuck) begin
      eq = 4'h0; er = 4'h0; edbz = 1'b0; eerr = 1'b1; elat = TIMEOUT + 2;
    end else begin
      eq = a / b; er = a % b; edbz = 1'b0; eerr = 1'b0; elat = 8;
    end
    in_D = a; in_d = b; in_valid = 1'b1; out_ready = 1'b0;
    checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
    tick();
    n = 1;
    in_D = 4'($urandom); in_d = 4'($urandom);
    checkOutput("div_rst_c1", 32'(div_rst), 32'(b != 0));
    while (!out_valid && n < 60) begin
      checkOutput("busy_in_ready", 32'(in_ready), 32'd0);
      checkOutput("div_rst_busy", 32'(div_rst), 32'(n == 1 && b != 0));
      checkOutput("div_ops_held", 32'({div_D, div_d}), 32'({a, b}));
      tick();
      n++;
    end
    in_valid = 1'b0;
    checkOutput("latency", 32'(n), 32'(elat));
    for (int s = 0; s < stall; s++) begin
      checkOutput("stall_valid", 32'(out_valid), 32'd1);
      checkOutput("stall_q", 32'(out_q), 32'(eq));
      checkOutput("stall_r", 32'(out_r), 32'(er));
      checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    checkOutput("out_valid", 32'(out_valid), 32'd1);
    checkOutput("out_q", 32'(out_q), 32'(eq));
    checkOutput("out_r", 32'(out_r), 32'(er));
    checkOutput("out_dbz", 32'(out_dbz), 32'(edbz));
    checkOutput("out_err", 32'(out_err), 32'(eerr));
    tick();
    out_ready = 1'b0;
    checkOutput("post_valid", 32'(out_valid), 32'd0);
    checkOutput("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_D = '0; in_d = '0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
      checkOutput("rst_div_rst", 32'(div_rst), 32'd1);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    end
    rst = 1'b0;
    #1;
    checkOutput("init_in_ready", 32'(in_ready), 32'd1);
    checkOutput("init_div_rst", 32'(div_rst), 32'd0);
    checkOutput("init_out_q", 32'(out_q), 32'd0);
    checkOutput("init_out_r", 32'(out_r), 32'd0);
    checkOutput("init_flags", 32'({out_dbz, out_err}), 32'd0);
    checkOutput("init_div_ops", 32'({div_D, div_d}), 32'd0);

    applyStimulus(4'd13, 4'd3, 0, 1'b0);
    applyStimulus(4'd15, 4'd1, 0, 1'b0);
    applyStimulus(4'd2,  4'd7, 0, 1'b0);
    applyStimulus(4'd9,  4'd0, 0, 1'b0);
    applyStimulus(4'd7,  4'd2, 5, 1'b0);

    for (int i = 0; i < 20; i++) begin
      ra = 4'($urandom);
      rb = ($urandom_range(4, 0) == 0) ? 4'd0 : 4'($urandom_range(15, 1));
      applyStimulus(ra, rb, int'($urandom_range(3, 0)), 1'b0);
    end

    stuck = 1'b1;
    applyStimulus(4'd5, 4'd3, 0, 1'b1);

    // Abandon an operation while it is waiting on the divider.
    in_D = 4'd6; in_d = 4'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    #1;
    checkOutput("midrst_div_rst", 32'(div_rst), 32'd1);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("midrst_idle", 32'(in_ready), 32'd1);
    for (int i = 0; i < 20; i++) begin
      checkOutput("midrst_no_valid", 32'(out_valid), 32'd0);
      tick();
    end
    stuck = 1'b0;
    applyStimulus(4'd11, 4'd4, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
